// File: rtl/ring_access_arbiter.sv
// ring_access_arbiter
//   Shares one core's ring slot stream among NREQ local ring masters. It picks
//   one candidate master that may take the next Token and holds the other
//   requesters back through their waiting inhibits. While a master owns the
//   ring, its data, slot type and src/dest go onto the ring. At all other
//   times the upstream values pass straight through, with no added latency.
//
//   Optional feature macro: RING_ARB_STARVE_EN
//     Adds per-master starvation counters. A master that has lost
//     STARVE_LIMIT Tokens while requesting is forced to be the candidate.
//     When the macro is undefined the arbiter is pure round-robin and builds
//     no counters.
//
// Ports
//   clock        in   clock
//   reset        in   synchronous, active-high reset
//   RingIn       in   [31:0]         ring data from upstream
//   SlotTypeIn   in   [3:0]          slot type from upstream (Token=1, Null=7)
//   SrcDestIn    in   [3:0]          src/dest from upstream
//   req          in   [NREQ-1:0]     master i wants the ring
//   drive        in   [NREQ-1:0]     master i is driving the ring
//   mRingOut     in   [32*NREQ-1:0]  master ring data, slice i = [32i+31:32i]
//   mSlotType    in   [4*NREQ-1:0]   master slot types
//   mSrcDest     in   [4*NREQ-1:0]   master src/dest
//   waiting      out  [NREQ-1:0]     inhibit to requesting masters that are not the candidate or owner
//   grant        out  [NREQ-1:0]     one-hot ownership
//   RingOut      out  [31:0]         ring data downstream
//   SlotTypeOut  out  [3:0]          slot type downstream
//   SrcDestOut   out  [3:0]          src/dest downstream
//   busy         out                 arbiter not idle
//
// state   | meaning
// IDLE    | tracking a candidate; a Token may be taken by it
// OWNED   | owner's slices drive the ring until its drive drops
// RELEASE | one pass-through slot between successive owners
module ring_access_arbiter #(
  parameter int NREQ         = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [31:0]         RingIn,
  input  logic [3:0]          SlotTypeIn,
  input  logic [3:0]          SrcDestIn,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ-1:0]     drive,
  input  logic [32*NREQ-1:0]  mRingOut,
  input  logic [4*NREQ-1:0]   mSlotType,
  input  logic [4*NREQ-1:0]   mSrcDest,
  output logic [NREQ-1:0]     waiting,
  output logic [NREQ-1:0]     grant,
  output logic [31:0]         RingOut,
  output logic [3:0]          SlotTypeOut,
  output logic [3:0]          SrcDestOut,
  output logic                busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [3:0] SLOT_TOKEN = 4'd1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_OWNED   = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t        state, state_next;
  logic [PW-1:0] owner, owner_next;
  logic [PW-1:0] cand, cand_next;
  logic [PW-1:0] rr_ptr, rr_ptr_next;

  logic          token;
  logic          take;
  logic [PW-1:0] rr_pick;
  logic          rr_found;
  logic [PW-1:0] starve_pick;
  logic [NREQ-1:0] starved;
  logic [PW-1:0] pick;
  logic [PW-1:0] sel;

  assign token = (SlotTypeIn == SLOT_TOKEN);
  assign take  = (state == S_IDLE) && token && req[cand] && drive[cand];

  // First requester at or after rr_ptr, wrapping at NREQ. The loop runs from
  // the farthest offset down, so the nearest requester is the last one written.
  always_comb begin
    int idx;
    idx      = 0;
    rr_pick  = cand;
    rr_found = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (req[idx]) begin
        rr_found = 1'b1;
        rr_pick  = PW'(idx);
      end
    end
  end

`ifdef RING_ARB_STARVE_EN
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] CNT_SAT = CW'(STARVE_LIMIT);

  logic [CW-1:0] starve_cnt [NREQ];

  // Counts Tokens lost while requesting. The count clears once the master is
  // served or withdraws its request.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NREQ; i++) begin
      if (reset || !req[i] || grant[i]) begin
        starve_cnt[i] <= '0;
      end else if (token && (starve_cnt[i] != CNT_SAT)) begin
        starve_cnt[i] <= starve_cnt[i] + CW'(1);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      starved[i] = req[i] && (starve_cnt[i] == CNT_SAT);
    end
  end
`else
  assign starved = '0;
`endif

  // Among starved masters, the lowest index wins.
  always_comb begin
    starve_pick = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (starved[i]) starve_pick = PW'(i);
    end
  end

  always_comb begin
    if (|starved)      pick = starve_pick;
    else if (rr_found) pick = rr_pick;
    else               pick = cand;
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= S_IDLE;
      owner  <= '0;
      cand   <= '0;
      rr_ptr <= '0;
    end else begin
      state  <= state_next;
      owner  <= owner_next;
      cand   <= cand_next;
      rr_ptr <= rr_ptr_next;
    end
  end

  // Next-state logic. The candidate is also refreshed during RELEASE, where
  // rr_ptr already points past the old owner. This way a Token in the first
  // IDLE slot never goes back to the previous owner.
  always_comb begin
    state_next  = state;
    owner_next  = owner;
    cand_next   = cand;
    rr_ptr_next = rr_ptr;
    case (state)
      S_IDLE: begin
        cand_next = pick;
        if (take) begin
          owner_next = cand;
          state_next = S_OWNED;
        end
      end
      S_OWNED: begin
        if (!drive[owner]) begin
          state_next  = S_RELEASE;
          rr_ptr_next = (owner == PW'(NREQ - 1)) ? '0 : owner + PW'(1);
        end
      end
      S_RELEASE: begin
        cand_next  = pick;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Outputs. The grant in the Take cycle is combinational, so the master's
  // modified Token leaves in the same slot.
  always_comb begin
    grant   = '0;
    sel     = cand;
    waiting = '0;
    if (state == S_OWNED) begin
      grant[owner] = 1'b1;
      sel          = owner;
    end else if (take) begin
      grant[cand] = 1'b1;
    end
    for (int i = 0; i < NREQ; i++) begin
      waiting[i] = req[i] && !grant[i] && !((state == S_IDLE) && (cand == PW'(i)));
    end
    if (|grant) begin
      RingOut     = mRingOut[32*int'(sel) +: 32];
      SlotTypeOut = mSlotType[4*int'(sel) +: 4];
      SrcDestOut  = mSrcDest[4*int'(sel) +: 4];
    end else begin
      RingOut     = RingIn;
      SlotTypeOut = SlotTypeIn;
      SrcDestOut  = SrcDestIn;
    end
    busy = (state != S_IDLE);
  end

endmodule

// File: tb/tb_ring_access_arbiter.sv
module tb_ring_access_arbiter;

  localparam int N = 4;
  localparam logic [3:0] TOK = 4'd1;
  localparam logic [3:0] NUL = 4'd7;

  logic            clock = 1'b0;
  logic            reset;
  logic [31:0]     RingIn;
  logic [3:0]      SlotTypeIn, SrcDestIn;
  logic [N-1:0]    req, drive;
  logic [32*N-1:0] mRingOut;
  logic [4*N-1:0]  mSlotType, mSrcDest;
  logic [N-1:0]    waiting, grant;
  logic [31:0]     RingOut;
  logic [3:0]      SlotTypeOut, SrcDestOut;
  logic            busy;

  int vectors = 0;
  int miscompares = 0;

  ring_access_arbiter #(.NREQ(N), .STARVE_LIMIT(2)) dut (
    .clock(clock), .reset(reset),
    .RingIn(RingIn), .SlotTypeIn(SlotTypeIn), .SrcDestIn(SrcDestIn),
    .req(req), .drive(drive),
    .mRingOut(mRingOut), .mSlotType(mSlotType), .mSrcDest(mSrcDest),
    .waiting(waiting), .grant(grant),
    .RingOut(RingOut), .SlotTypeOut(SlotTypeOut), .SrcDestOut(SrcDestOut),
    .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_ring(input int i);
    return 32'hC0DE_0000 + 32'(i);
  endfunction

  initial begin
    int order [5];
    logic [3:0] oh;
    order = '{0, 1, 2, 3, 0};
    reset = 1'b1; req = '0; drive = '0;
    RingIn = '0; SlotTypeIn = NUL; SrcDestIn = '0;
    for (int i = 0; i < N; i++) begin
      mRingOut[32*i +: 32] = m_ring(i);
      mSlotType[4*i +: 4]  = 4'hA + 4'(i);
      mSrcDest[4*i +: 4]   = 4'h4 + 4'(i);
    end
    repeat (2) @(negedge clock);
    #1 chk("rst_grant", grant, 0); chk("rst_busy", busy, 0); chk("rst_waiting", waiting, 0);
    reset = 1'b0;

    // 1: pass-through with no requests
    @(negedge clock); RingIn = 32'h1234_5678; SlotTypeIn = TOK; SrcDestIn = 4'h3;
    #1 chk("t1_ring_tok", RingOut, 32'h1234_5678); chk("t1_slot_tok", SlotTypeOut, TOK);
    chk("t1_src_tok", SrcDestOut, 4'h3); chk("t1_grant", grant, 0); chk("t1_busy", busy, 0);
    @(negedge clock); RingIn = 32'hDEAD_BEEF; SlotTypeIn = NUL; SrcDestIn = 4'h9;
    #1 chk("t1_ring_nul", RingOut, 32'hDEAD_BEEF); chk("t1_slot_nul", SlotTypeOut, NUL);
    chk("t1_src_nul", SrcDestOut, 4'h9);

    // 2: single master takes a token and holds for 10 cycles
    mRingOut[31:0] = 32'd6;
    @(negedge clock); req = 4'b0001; drive = '0;
    #1 chk("t2_wait_idle", waiting, 0);
    @(negedge clock); RingIn = 32'd5; SlotTypeIn = TOK; drive = 4'b0001;
    #1 chk("t2_take_grant", grant, 4'b0001); chk("t2_take_ring", RingOut, 32'd6);
    chk("t2_take_slot", SlotTypeOut, 4'hA); chk("t2_take_src", SrcDestOut, 4'h4);
    for (int c = 1; c < 10; c++) begin
      @(negedge clock); req = '0; RingIn = 32'(c); SlotTypeIn = NUL;
      #1 chk("t2_own_grant", grant, 4'b0001); chk("t2_own_busy", busy, 1);
      chk("t2_own_ring", RingOut, 32'd6);
    end
    @(negedge clock); drive = '0;
    #1 chk("t2_drop_grant", grant, 4'b0001);
    @(negedge clock); RingIn = 32'h77;
    #1 chk("t2_rel_grant", grant, 0); chk("t2_rel_busy", busy, 1); chk("t2_rel_ring", RingOut, 32'h77);
    @(negedge clock);
    #1 chk("t2_idle_busy", busy, 0);
    req = 4'hF;
    @(negedge clock);
    #1 chk("t2_rrptr_cand1", waiting, 4'b1101);
    @(negedge clock); reset = 1'b1; req = '0;
    @(negedge clock); reset = 1'b0;
    mRingOut[31:0] = m_ring(0);

    // 3: all requesting, round-robin order 0,1,2,3,0
    req = 4'hF;
    for (int j = 0; j < 5; j++) begin
      oh = 4'b0001 << order[j];
      SlotTypeIn = NUL; drive = '0;
      #1 chk("t3_wait_idle", waiting, 4'hF & ~oh);
      @(negedge clock); SlotTypeIn = TOK; drive = oh; RingIn = 32'h100 + 32'(j);
      #1 chk("t3_take_grant", grant, oh); chk("t3_take_ring", RingOut, m_ring(order[j]));
      for (int c = 0; c < 2; c++) begin
        @(negedge clock); SlotTypeIn = NUL; drive = oh | (4'b0001 << ((order[j] + 1) % N));
        #1 chk("t3_own_grant", grant, oh); chk("t3_own_ring", RingOut, m_ring(order[j]));
      end
      @(negedge clock); drive = '0;
      #1 chk("t3_drop_grant", grant, oh);
      @(negedge clock);
      #1 chk("t3_rel_grant", grant, 0);
      @(negedge clock);
    end

    // 4: candidate's request drops in the token cycle
    req = 4'b0100; SlotTypeIn = NUL; drive = '0;
    @(negedge clock);
    #1 chk("t4_cand2", waiting, 0);
    req = 4'b0010; drive = 4'b0010; SlotTypeIn = TOK; RingIn = 32'hABCD_0004; SrcDestIn = 4'h5;
    #1 chk("t4_tok_grant", grant, 0); chk("t4_tok_ring", RingOut, 32'hABCD_0004);
    chk("t4_tok_slot", SlotTypeOut, TOK); chk("t4_tok_wait", waiting, 4'b0010);
    @(negedge clock); SlotTypeIn = NUL; drive = '0;
    #1 chk("t4_cand1", waiting, 0);
    @(negedge clock); SlotTypeIn = TOK; drive = 4'b0010;
    #1 chk("t4_take1", grant, 4'b0010);
    @(negedge clock); SlotTypeIn = NUL; drive = '0;
    #1 chk("t4_drop", grant, 4'b0010);
    @(negedge clock);
    #1 chk("t4_rel_busy", busy, 1); chk("t4_rel_grant", grant, 0);

    // 5: reset while owned by master 3
    @(negedge clock); req = 4'b1000;
    @(negedge clock); SlotTypeIn = TOK; drive = 4'b1000;
    #1 chk("t5_take3", grant, 4'b1000);
    @(negedge clock); SlotTypeIn = NUL;
    #1 chk("t5_own3", grant, 4'b1000); chk("t5_own_busy", busy, 1);
    reset = 1'b1;
    @(negedge clock); reset = 1'b0; req = 4'hF; RingIn = 32'h5555;
    #1 chk("t5_rst_grant", grant, 0); chk("t5_rst_busy", busy, 0);
    chk("t5_rst_ring", RingOut, 32'h5555); chk("t5_rst_wait", waiting, 4'b1110);
    @(negedge clock);
    #1 chk("t5_rrptr0", waiting, 4'b1110);

`ifdef RING_ARB_STARVE_EN
    // 6: starvation override with STARVE_LIMIT=2
    @(negedge clock); reset = 1'b1; req = '0; drive = '0;
    @(negedge clock); reset = 1'b0; req = 4'b0010;
    @(negedge clock); SlotTypeIn = TOK; drive = 4'b0010;
    #1 chk("t6_take1", grant, 4'b0010);
    @(negedge clock); SlotTypeIn = NUL; drive = '0;
    @(negedge clock); req = 4'hF;
    @(negedge clock); SlotTypeIn = TOK; drive = 4'b0001;
    #1 chk("t6_lose1", grant, 0);
    @(negedge clock); SlotTypeIn = NUL;
    @(negedge clock); SlotTypeIn = TOK;
    #1 chk("t6_lose2", grant, 0);
    @(negedge clock); SlotTypeIn = NUL;
    @(negedge clock);
    #1 chk("t6_forced_cand0", waiting, 4'b1110);
    SlotTypeIn = TOK;
    #1 chk("t6_take0", grant, 4'b0001);
    @(negedge clock); SlotTypeIn = NUL; drive = '0;
    @(negedge clock);
    @(negedge clock);
    #1 chk("t6_cnt0_cleared", waiting, 4'b1101);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
